// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store path: funct3 access encodings,
// the LSU state enum and small decode helpers used by the LSU.
package riscv_pkg;

    // Load/store width encodings carried in funct3
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // LSU control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // True for the five funct3 values the LSU knows how to execute
    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            LS_B, LS_H, LS_W, LS_BU, LS_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // True when the low address bits suit the access width
    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3)
            LS_H, LS_HU: ok = (lo[0] == 1'b0);
            LS_W:        ok = (lo == 2'b00);
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword from a read word and sign- or
// zero-extends it to 32 bits according to funct3.
module load_extend
    import riscv_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension of the returned word
    always_comb begin
        byte_s  = rdata[{addr_lo, 3'b000} +: 8];
        half_s  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ld_data = 32'h0000_0000;
        case (funct3)
            LS_B:    ld_data = {{24{byte_s[7]}}, byte_s};
            LS_H:    ld_data = {{16{half_s[15]}}, half_s};
            LS_W:    ld_data = rdata;
            LS_BU:   ld_data = {24'h00_0000, byte_s};
            LS_HU:   ld_data = {16'h0000, half_s};
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a core access request into a single-beat memory
// transaction with byte enables, waits for ack with a bounded timeout and
// returns the extended load result. Misaligned and illegal accesses are
// rejected in IDLE without touching the bus.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lsu_valid,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_data,
    output logic        o_lsu_done,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    // Counter value on the last REQ cycle before the access is abandoned
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_r, state_s;
    logic [31:0] addr_r;
    logic [2:0]  funct3_r;
    logic        wren_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic [7:0]  wait_cnt_r;
    logic [31:0] ld_data_r;
    logic        bus_err_r;

    logic        ok_s;
    logic        in_idle_s;
    logic        in_req_s;
    logic        accept_s;
    logic        reject_s;
    logic        timeout_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ext_s;

    assign ok_s      = f3_legal(i_funct3) & f3_aligned(i_funct3, i_lsu_addr[1:0]);
    assign in_idle_s = (state_r == ST_IDLE);
    assign in_req_s  = (state_r == ST_REQ);
    assign accept_s  = in_idle_s & i_lsu_valid & ok_s;
    assign reject_s  = in_idle_s & i_lsu_valid & ~ok_s;
    // Ack wins over a timeout landing in the same cycle
    assign timeout_s = in_req_s & ~i_mem_ack & (wait_cnt_r == TIMEOUT_LAST);

    // Byte enables and store-data lane replication for the incoming request
    always_comb begin
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
        case (i_funct3)
            LS_B, LS_BU: begin
                be_s    = 4'b0001 << i_lsu_addr[1:0];
                wdata_s = {4{i_st_data[7:0]}};
            end
            LS_H, LS_HU: begin
                be_s    = 4'b0011 << i_lsu_addr[1:0];
                wdata_s = {2{i_st_data[15:0]}};
            end
            LS_W: begin
                be_s    = 4'b1111;
                wdata_s = i_st_data;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Next-state logic for the IDLE -> REQ -> DONE handshake
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_mem_ack) begin
                    state_s = ST_DONE;
                end else if (timeout_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and bus-error pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            bus_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            bus_err_r <= timeout_s;
        end
    end

    // Capture of the accepted request; held stable for the whole transaction
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            addr_r   <= 32'h0000_0000;
            funct3_r <= 3'b000;
            wren_r   <= 1'b0;
            be_r     <= 4'b0000;
            wdata_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            addr_r   <= i_lsu_addr;
            funct3_r <= i_funct3;
            wren_r   <= i_lsu_wren;
            be_r     <= be_s;
            wdata_r  <= wdata_s;
        end
    end

    // Wait counter: zeroed on REQ entry, counts REQ cycles without ack
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wait_cnt_r <= 8'h00;
        end else if (accept_s) begin
            wait_cnt_r <= 8'h00;
        end else if (in_req_s && !i_mem_ack) begin
            wait_cnt_r <= wait_cnt_r + 8'h01;
        end
    end

    load_extend u_load_extend (
        .addr_lo (addr_r[1:0]),
        .funct3  (funct3_r),
        .rdata   (i_mem_rdata),
        .ld_data (ext_s)
    );

    // Load result register: updated only by a completed load
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ld_data_r <= 32'h0000_0000;
        end else if (in_req_s && i_mem_ack && !wren_r) begin
            ld_data_r <= ext_s;
        end
    end

    assign o_mem_req    = in_req_s;
    assign o_mem_we     = in_req_s & wren_r;
    assign o_mem_addr   = {addr_r[31:2], 2'b00};
    assign o_mem_be     = be_r;
    assign o_mem_wdata  = wdata_r;
    assign o_ld_data    = ld_data_r;
    assign o_bus_err    = bus_err_r;
    // Rejection is reported in the request cycle so the core never stalls on it
    assign o_misaligned = reject_s & i_rst_n;
    assign o_lsu_done   = (state_r == ST_DONE) | o_misaligned | bus_err_r;
    assign o_stall      = in_req_s | (accept_s & i_rst_n);

endmodule
